// File: rtl/tile_hash_lookup_if.sv
// Bus bundle for tile_hash_lookup: hash input stream, dictionary write port and result handshake.
// master = host/upstream/downstream side, slave = the lookup engine.
interface tile_hash_lookup_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int VALUE_W     = 12
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic               hash_valid;
  logic [15:0]        hash_in;
  logic               hash_ready;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [15:0]        wr_key;
  logic [VALUE_W-1:0] wr_value;
  logic               wr_entry_valid;

  logic               res_valid;
  logic               res_ready;
  logic               res_hit;
  logic [IDX_W-1:0]   res_index;
  logic [VALUE_W-1:0] res_value;

  modport master (
    output hash_valid, hash_in, wr_en, wr_addr, wr_key, wr_value, wr_entry_valid, res_ready,
    input  hash_ready, res_valid, res_hit, res_index, res_value
  );

  modport slave (
    input  hash_valid, hash_in, wr_en, wr_addr, wr_key, wr_value, wr_entry_valid, res_ready,
    output hash_ready, res_valid, res_hit, res_index, res_value
  );
endinterface

// File: rtl/tile_hash_lookup.sv
// Sequential dictionary search for tile CRC-16 hashes, one entry per clock, lowest index wins.
// Optional hit/miss statistics are enabled by defining TILE_LOOKUP_STATS_EN.
module tile_hash_lookup #(
  parameter  int NUM_ENTRIES = 16,
  parameter  int VALUE_W     = 12,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tile_hash_lookup_if.slave     bus,
  input  logic                  err_clr,
  input  logic                  tbl_clr,
  output logic                  drop_err,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  typedef enum logic [1:0] {IDLE, SEARCH, RESULT} state_t;

  state_t state, state_nxt;

  logic [15:0]        key_q;
  logic [IDX_W-1:0]   idx_q;

  logic [15:0]        entry_key   [NUM_ENTRIES];
  logic [VALUE_W-1:0] entry_value [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] entry_valid;

  logic match, last, accept, res_fire;

  // The compare reads the registered table, so a same-cycle write is seen only from the next edge.
  assign match    = entry_valid[idx_q] && (entry_key[idx_q] == key_q);
  assign last     = (idx_q == IDX_W'(NUM_ENTRIES - 1));
  assign accept   = (state == IDLE) && bus.hash_valid;
  assign res_fire = bus.res_valid && bus.res_ready;

  assign bus.hash_ready = (state == IDLE);
  assign bus.res_valid  = (state == RESULT);

  // NOTE: non-blocking assignments in every clocked block so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.hash_valid) state_nxt = SEARCH;
      SEARCH:  if (match || last)  state_nxt = RESULT;
      RESULT:  if (res_fire)       state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q         <= '0;
      idx_q         <= '0;
      bus.res_hit   <= 1'b0;
      bus.res_index <= '0;
      bus.res_value <= '0;
    end else begin
      if (accept) begin
        key_q <= bus.hash_in;
        idx_q <= '0;
      end else if (state == SEARCH) begin
        if (match) begin
          bus.res_hit   <= 1'b1;
          bus.res_index <= idx_q;
          bus.res_value <= entry_value[idx_q];
        end else if (last) begin
          bus.res_hit   <= 1'b0;
          bus.res_index <= '0;
          bus.res_value <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

  // NOTE: key/value storage carries no reset; only the valid bits need a defined state.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      entry_key[bus.wr_addr]   <= bus.wr_key;
      entry_value[bus.wr_addr] <= bus.wr_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          entry_valid <= '0;
    else if (tbl_clr)    entry_valid <= '0;
    else if (bus.wr_en)  entry_valid[bus.wr_addr] <= bus.wr_entry_valid;
  end

  // A drop on the same edge as err_clr must stay visible, so set takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drop_err <= 1'b0;
    else if (bus.hash_valid && !bus.hash_ready) drop_err <= 1'b1;
    else if (err_clr)                          drop_err <= 1'b0;
  end

`ifdef TILE_LOOKUP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (err_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (res_fire) begin
      if (bus.res_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`else
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
`endif

endmodule

// File: doc/tile_hash_lookup.md
Name: tile_hash_lookup

Overview:
- Downstream consumer of the tile CRC-16 hash stream.
- Takes each 16-bit tile hash and searches a host-programmable dictionary of known hashes, one entry per clock.
- Returns hit/miss, the matching entry index and the replacement value (translated-glyph ID) to the tile substitution stage.
- Dictionary contents are written by the host/loader through a simple write port.

Parameters:
- NUM_ENTRIES, 16: dictionary depth; must be ≥2.
- VALUE_W, 12: width of the replacement value stored per entry.
- IDX_W, $clog2(NUM_ENTRIES): entry index width (derived; do not override).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hash_valid  in  1  one-cycle pulse, hash_in valid.
- hash_in  in  16  tile hash from the CRC-16 generator.
- hash_ready  out  1  high when a new hash can be accepted.
- drop_err  out  1  sticky: a hash arrived while hash_ready=0.
- err_clr  in  1  clears drop_err.
- wr_en  in  1  dictionary write strobe.
- wr_addr  in  IDX_W  entry to write.
- wr_key  in  16  hash key for the entry.
- wr_value  in  VALUE_W  replacement value.
- wr_entry_valid  in  1  valid bit written with the entry; 0 deletes the entry.
- tbl_clr  in  1  invalidates all entries in one cycle.
- res_valid  out  1  result available; held until res_ready.
- res_ready  in  1  downstream accepts the result.
- res_hit  out  1  1 = match found.
- res_index  out  IDX_W  matching entry index; 0 on miss.
- res_value  out  VALUE_W  matching value; 0 on miss.
- hit_count  out  16  hit statistics; see Optional Feature.
- miss_count  out  16  miss statistics; see Optional Feature.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - all entry valid bits = 0; state = IDLE.
  - hash_ready=1; res_valid=0, res_hit=0, res_index=0, res_value=0.
  - drop_err=0; counters=0.
  - Any search in flight is abandoned and no result is emitted.
- States: IDLE, SEARCH, RESULT.
- IDLE:
  - hash_ready=1.
  - hash_valid=1 latches hash_in into the key register, sets idx=0 and moves to SEARCH.
- SEARCH:
  - hash_ready=0.
  - Each cycle compares entry[idx] (valid && key==latched key).
  - Match: res_hit=1, res_index=idx, res_value=entry value, go to RESULT.
  - No match and idx==NUM_ENTRIES-1: res_hit=0, index/value=0, go to RESULT.
  - Otherwise idx+1.
- RESULT:
  - res_valid=1; outputs stable until the res_valid && res_ready edge, then IDLE.
  - hash_ready=0.
- Latency, counted in rising edges after the accepting edge to res_valid=1:
  - hit at entry k: k+1.
  - miss: NUM_ENTRIES.
  - With res_ready tied high, the next accept is possible 2 edges after res_valid rises.
- Duplicate keys: the lowest index wins, because the scan is ascending.
- Drops:
  - hash_valid while hash_ready=0 discards the hash and sets drop_err.
  - The current search is unaffected.
  - drop_err holds until err_clr; if set and clear coincide, set wins.
- Writes:
  - Accepted in any state; take effect at the next edge.
  - A compare in the same cycle uses the pre-write contents of that entry.
  - Entries not yet scanned see new contents.
- tbl_clr:
  - Clears all valid bits at the next edge.
  - If it coincides with wr_en, tbl_clr wins.
  - A search in progress continues and sees cleared entries, so it ends in a miss unless it already hit.
- Throughput: the upstream hash generator emits at most one hash per 17 cycles, but a full miss scan takes NUM_ENTRIES+2. With the default depth, arrivals closer than 18 cycles are dropped and flagged; the design tolerates this and does not buffer.

Optional Feature:
- Macro: TILE_LOOKUP_STATS_EN.
- Defined:
  - hit_count and miss_count increment on each result handshake according to res_hit.
  - Each counter saturates at 16'hFFFF.
  - Both are cleared by reset and by err_clr.
- Undefined: both ports are driven constant 0 and no counter logic is synthesized.

Test Plan:
- Reset, then write entry 3 = {key 16'hBEEF, value 12'h123, valid}. Send hash 16'hBEEF with res_ready=1 -> res_valid on the 4th edge after accept; res_hit=1, res_index=3, res_value=12'h123.
- Send hash 16'h1234, which is absent -> res_valid on edge 16; res_hit=0, index=0, value=0; hash_ready=0 throughout the search.
- Write key 16'hA5A5 into entries 9 and 2, then look up 16'hA5A5 -> res_index=2. Delete entry 2 (wr_entry_valid=0) and repeat -> res_index=9.
- Hold res_ready=0 for 10 cycles after a hit -> res_valid and outputs stay stable, hash_ready=0. A hash_valid pulse during this window sets drop_err, and the held result is unchanged.
- Start a lookup of 16'hBEEF, which matches entry 12, and pulse tbl_clr at the 3rd search cycle -> miss. Separately, assert rst_n=0 mid-search -> res_valid=0 immediately, hash_ready=1, and no result follows.
- With TILE_LOOKUP_STATS_EN defined, run 3 hits and 2 misses -> hit_count=3, miss_count=2; err_clr zeroes both. With the macro undefined, both ports read 0.
